// File: rtl/dcache_axi_mem_slave.sv
// ---------------------------------------------------------------------------
// dcache_axi_mem_slave
//   Main-memory stand-in for the data cache's simplified AXI master port.
//   Serves single-beat uncached accesses and 16-beat line bursts out of an
//   internal word-addressed RAM (2^ADDR_WIDTH x 32 bit, contents not reset).
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   r_req/r_addr/r_size/r_length -> r_rdy      read address channel
//   ret_valid/ret_last/r_data_AXI <- r_data_ready  read data channel
//   w_req/w_addr/w_size/w_length -> w_rdy      write address channel
//   w_data_req/w_data_AXI/w_strb/w_last -> w_data_ready  write data channel
//   b_valid <- b_ready                          write response
//   proto_err                                   sticky protocol error flag
//
// Optional build macro
//   DMEM_RAND_STALL_EN : a 16-bit LFSR inserts random beat stalls and delays
//                        address acceptance. Undefined = fixed timing.
// ---------------------------------------------------------------------------
module dcache_axi_mem_slave #(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r_req,
    input  logic [31:0] r_addr,
    input  logic [2:0]  r_size,
    input  logic [7:0]  r_length,
    output logic        r_rdy,
    output logic        ret_valid,
    output logic        ret_last,
    output logic [31:0] r_data_AXI,
    input  logic        r_data_ready,
    input  logic        w_req,
    input  logic [31:0] w_addr,
    input  logic [2:0]  w_size,
    input  logic [7:0]  w_length,
    output logic        w_rdy,
    input  logic        w_data_req,
    input  logic [31:0] w_data_AXI,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    output logic        w_data_ready,
    output logic        b_valid,
    input  logic        b_ready,
    output logic        proto_err
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, R_LAT, R_BEAT, W_BEAT, W_RESP} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [7:0]            len_q, cnt_q;
    logic [LAT_W-1:0]      lat_q;
    logic                  r_rdy_q, w_rdy_q, ret_valid_q, ret_last_q;
    logic                  w_data_ready_q, b_valid_q, proto_err_q;
    logic [31:0]           r_data_q;
    logic [31:0]           mem [DEPTH];

    logic                  beat_stall, req_hold;
    logic                  r_hs, w_hs;
    logic [ADDR_WIDTH-1:0] word_d;
    logic [7:0]            cnt_d;

`ifdef DMEM_RAND_STALL_EN
    // Fibonacci LFSR, taps 16,14,13,11
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign beat_stall = lfsr_q[0];
    assign req_hold   = lfsr_q[1];
    logic unused_addr;
    assign unused_addr = ^{r_addr[31:ADDR_WIDTH+2], r_addr[1:0],
                           w_addr[31:ADDR_WIDTH+2], w_addr[1:0]};
`else
    assign beat_stall = 1'b0;
    assign req_hold   = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{r_addr[31:ADDR_WIDTH+2], r_addr[1:0],
                           w_addr[31:ADDR_WIDTH+2], w_addr[1:0], LFSR_SEED};
`endif

    // Stalls mask the handshake outputs so no beat can transfer that cycle
    assign ret_valid    = ret_valid_q & ~beat_stall;
    assign w_data_ready = w_data_ready_q & ~beat_stall;
    assign r_hs         = ret_valid & r_data_ready;
    assign w_hs         = w_data_ready & w_data_req;

    // Word address wraps naturally at the top of memory
    assign word_d = word_q + 1'b1;
    assign cnt_d  = cnt_q + 8'd1;

    assign r_rdy      = r_rdy_q;
    assign w_rdy      = w_rdy_q;
    assign ret_last   = ret_last_q;
    assign r_data_AXI = r_data_q;
    assign b_valid    = b_valid_q;
    assign proto_err  = proto_err_q;

    // RAM write port: byte-enabled, committed on the beat handshake
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[word_q][8*b +: 8] <= w_data_AXI[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            word_q         <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            lat_q          <= '0;
            r_rdy_q        <= 1'b0;
            w_rdy_q        <= 1'b0;
            ret_valid_q    <= 1'b0;
            ret_last_q     <= 1'b0;
            w_data_ready_q <= 1'b0;
            b_valid_q      <= 1'b0;
            proto_err_q    <= 1'b0;
            r_data_q       <= '0;
        end else begin
            r_rdy_q <= 1'b0;
            w_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Writes win so a dirty writeback lands before its refill
                    if (!req_hold && w_req) begin
                        w_rdy_q        <= 1'b1;
                        word_q         <= w_addr[ADDR_WIDTH+1:2];
                        len_q          <= w_length;
                        cnt_q          <= '0;
                        w_data_ready_q <= 1'b1;
                        if (w_length != 8'd0 && w_size != 3'd2) proto_err_q <= 1'b1;
                        state_q        <= W_BEAT;
                    end else if (!req_hold && r_req) begin
                        r_rdy_q <= 1'b1;
                        word_q  <= r_addr[ADDR_WIDTH+1:2];
                        len_q   <= r_length;
                        cnt_q   <= '0;
                        lat_q   <= LAT_W'(READ_LATENCY - 1);
                        if (r_length != 8'd0 && r_size != 3'd2) proto_err_q <= 1'b1;
                        state_q <= R_LAT;
                    end
                end
                R_LAT: begin
                    if (lat_q == '0) begin
                        ret_valid_q <= 1'b1;
                        ret_last_q  <= (len_q == 8'd0);
                        r_data_q    <= mem[word_q];
                        state_q     <= R_BEAT;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                R_BEAT: begin
                    // Data/valid/last only move on a handshake, so they hold across stalls
                    if (r_hs) begin
                        if (ret_last_q) begin
                            ret_valid_q <= 1'b0;
                            ret_last_q  <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            word_q     <= word_d;
                            cnt_q      <= cnt_d;
                            r_data_q   <= mem[word_d];
                            ret_last_q <= (cnt_d == len_q);
                        end
                    end
                end
                W_BEAT: begin
                    if (w_hs) begin
                        word_q <= word_d;
                        cnt_q  <= cnt_d;
                        // w_last must coincide with the final counted beat
                        if (w_last != (cnt_q == len_q)) proto_err_q <= 1'b1;
                        if (w_last || cnt_q == len_q) begin
                            w_data_ready_q <= 1'b0;
                            b_valid_q      <= 1'b1;
                            state_q        <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_axi_mem_slave.sv
module tb_dcache_axi_mem_slave;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;
    localparam int RL    = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r_req, r_rdy, ret_valid, ret_last, r_data_ready;
    logic [31:0] r_addr, r_data_AXI;
    logic [2:0]  r_size, w_size;
    logic [7:0]  r_length, w_length;
    logic        w_req, w_rdy, w_data_req, w_last, w_data_ready, b_valid, b_ready, proto_err;
    logic [31:0] w_addr, w_data_AXI;
    logic [3:0]  w_strb;

    dcache_axi_mem_slave #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rstn(rstn),
        .r_req(r_req), .r_addr(r_addr), .r_size(r_size), .r_length(r_length), .r_rdy(r_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .r_data_AXI(r_data_AXI), .r_data_ready(r_data_ready),
        .w_req(w_req), .w_addr(w_addr), .w_size(w_size), .w_length(w_length), .w_rdy(w_rdy),
        .w_data_req(w_data_req), .w_data_AXI(w_data_AXI), .w_strb(w_strb), .w_last(w_last),
        .w_data_ready(w_data_ready), .b_valid(b_valid), .b_ready(b_ready), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: flat word array plus expected sticky error flag
    logic [31:0] mdl [DEPTH];
    bit          pexp;
    int          total = 0, bad = 0;
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] last_rd;
    int          rrdy_cnt = 0;

    always @(negedge clk) if (r_rdy === 1'b1) rrdy_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge
    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size, input int lastidx);
        int g, i, word, exp_beats;
        bit done;
        w_req = 1; w_addr = addr; w_size = size; w_length = 8'(len);
        g = 0;
        do begin @(negedge clk); g++; end while (w_rdy !== 1'b1 && g < 20);
        chk("w_rdy", w_rdy, 1);
        w_req = 0;
        if (len != 0 && size != 3'd2) pexp = 1;
        if (lastidx != len) pexp = 1;
        exp_beats = ((lastidx < len) ? lastidx : len) + 1;
        i = 0; done = 0; g = 0;
        while (!done && g < 600) begin
            w_data_req = 1; w_data_AXI = wdat[i]; w_strb = wstb[i]; w_last = (i == lastidx);
            if (w_data_ready === 1'b1) begin
                @(posedge clk);
                word = ((addr >> 2) + i) % DEPTH;
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[word][8*b +: 8] = wdat[i][8*b +: 8];
                done = (i == lastidx) || (i == len);
                i++;
            end
            @(negedge clk); g++;
        end
        w_data_req = 0; w_last = 0;
        chk("w_beats", i, exp_beats);
        g = 0;
        while (b_valid !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        chk("b_valid", b_valid, 1);
        chk("w_dready_off", w_data_ready, 0);
        b_ready = 1; @(negedge clk); b_ready = 0;
        chk("b_clear", b_valid, 0);
        chk("proto_w", proto_err, pexp);
    endtask

    // mode: 0 always ready, 1 toggling 1,0,1,0, 2 random
    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size, input int mode);
        int g, k, beat, word;
        bit rdy, tog;
        r_req = 1; r_addr = addr; r_size = size; r_length = 8'(len);
        g = 0;
        do begin @(negedge clk); g++; end while (r_rdy !== 1'b1 && g < 60);
        chk("r_rdy", r_rdy, 1);
        r_req = 0;
        if (len != 0 && size != 3'd2) pexp = 1;
        k = 0;
        while (ret_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("rd_lat", k, RL);
        beat = 0; g = 0; tog = 1;
        while (beat <= len && g < 800) begin
            case (mode)
                0:       rdy = 1;
                1:       rdy = tog;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            r_data_ready = rdy;
            word = ((addr >> 2) + beat) % DEPTH;
            chk("ret_valid", ret_valid, 1);
            chk("rd_data", r_data_AXI, mdl[word]);
            chk("ret_last", ret_last, (beat == len));
            if (rdy) begin
                last_rd = r_data_AXI;
                @(posedge clk);
                beat++;
            end
            @(negedge clk); g++;
        end
        r_data_ready = 0;
        chk("rd_done", ret_valid, 0);
        chk("proto_r", proto_err, pexp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  rsize;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int g, beat, len, op;
        logic [31:0] a;
        int c0;

        vt[0] = '{32'h0000_0080, 32'h0000_00AA, 4'b0001, 3'd2, 32'h1122_33AA};
        vt[1] = '{32'h0000_0086, 32'hBB00_0000, 4'b1000, 3'd0, 32'hBB22_3344};
        vt[2] = '{32'h0000_0088, 32'h00CC_DD00, 4'b0110, 3'd1, 32'h11CC_DD44};
        vt[3] = '{32'h0000_008C, 32'h0000_0000, 4'b0000, 3'd2, 32'h1122_3344};
        vt[4] = '{32'h0000_0091, 32'hCAFE_F00D, 4'b1111, 3'd2, 32'hCAFE_F00D};

        rstn = 0; pexp = 0;
        r_req = 0; r_addr = 0; r_size = 0; r_length = 0; r_data_ready = 0;
        w_req = 0; w_addr = 0; w_size = 0; w_length = 0;
        w_data_req = 0; w_data_AXI = 0; w_strb = 0; w_last = 0; b_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_r_rdy", r_rdy, 0);
        chk("rst_w_rdy", w_rdy, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_last", ret_last, 0);
        chk("rst_rdata", r_data_AXI, 0);
        chk("rst_w_dready", w_data_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_proto", proto_err, 0);
        rstn = 1;
        @(negedge clk);

        // Prefill words 0..255 with one maximal burst
        for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(32'h0, 255, 3'd2, 255);

        // Single-beat write then read
        wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
        do_write(32'h40, 0, 3'd2, 0);
        do_read(32'h40, 0, 3'd2, 0);
        chk("single", last_rd, 32'hDEAD_BEEF);

        // Byte strobes and narrow reads
        for (int v = 0; v < 5; v++) begin
            wdat[0] = 32'h1122_3344; wstb[0] = 4'hF;
            do_write(vt[v].addr, 0, 3'd2, 0);
            wdat[0] = vt[v].wdata; wstb[0] = vt[v].strb;
            do_write(vt[v].addr, 0, 3'd2, 0);
            do_read(vt[v].addr, 0, vt[v].rsize, 0);
            chk("vec", last_rd, vt[v].exp);
        end

        // Line burst, read back with toggling ready
        for (int i = 0; i < 16; i++) begin wdat[i] = i; wstb[i] = 4'hF; end
        do_write(32'h100, 15, 3'd2, 15);
        do_read(32'h100, 15, 3'd2, 1);
        chk("line_last", last_rd, 32'd15);

        // Simultaneous requests: write first, read held off until after b handshake
        wdat[0] = 32'h5A5A_1234; wstb[0] = 4'hF;
        r_req = 1; r_addr = 32'h200; r_size = 3'd2; r_length = 0;
        c0 = rrdy_cnt;
        do_write(32'h200, 0, 3'd2, 0);
        chk("rd_held", rrdy_cnt, c0);
        do_read(32'h200, 0, 3'd2, 0);
        chk("simul", last_rd, 32'h5A5A_1234);

        // Wrap at top of memory
        wdat[0] = 32'hA0A0_A0A0; wdat[1] = 32'hA1A1_A1A1;
        wdat[2] = 32'hA2A2_A2A2; wdat[3] = 32'hA3A3_A3A3;
        for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
        do_write((DEPTH - 1) * 4, 3, 3'd2, 3);
        do_read((DEPTH - 1) * 4, 3, 3'd2, 2);
        do_read(32'h0, 0, 3'd2, 0);
        chk("wrap_w0", last_rd, 32'hA1A1_A1A1);
        do_read(32'h8, 0, 3'd2, 0);
        chk("wrap_w2", last_rd, 32'hA3A3_A3A3);

        // Early w_last, then late w_last; error is sticky
        for (int i = 0; i < 8; i++) begin wdat[i] = 32'h7000_0000 + i; wstb[i] = 4'hF; end
        do_write(32'h300, 3, 3'd2, 1);
        chk("proto_early", proto_err, 1);
        do_write(32'h310, 1, 3'd2, 5);
        do_read(32'h300, 1, 3'd2, 0);
        chk("proto_sticky", proto_err, 1);

        // Reset during beat 5 of a line read
        r_req = 1; r_addr = 32'h100; r_size = 3'd2; r_length = 8'd15; r_data_ready = 1;
        g = 0;
        do begin @(negedge clk); g++; end while (r_rdy !== 1'b1 && g < 20);
        r_req = 0;
        g = 0;
        while (ret_valid !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        beat = 0; g = 0;
        while (beat < 5 && g < 100) begin
            if (ret_valid === 1'b1) begin @(posedge clk); beat++; end
            @(negedge clk); g++;
        end
        chk("rst_b5_data", r_data_AXI, mdl[32'h40 + 5]);
        rstn = 0; #1;
        chk("mid_rst_valid", ret_valid, 0);
        chk("mid_rst_last", ret_last, 0);
        chk("mid_rst_proto", proto_err, 0);
        r_data_ready = 0; pexp = 0;
        @(negedge clk); rstn = 1; @(negedge clk);
        chk("post_rst_valid", ret_valid, 0);
        chk("post_rst_b", b_valid, 0);
        do_read(32'h104, 0, 3'd2, 0);
        chk("post_rst_rd", last_rd, 32'd1);

        // Narrow burst flags an error but still runs as word beats
        do_read(32'h100, 1, 3'd0, 0);
        chk("proto_narrow", proto_err, 1);

        // Random traffic in the prefilled region
        for (int n = 0; n < 40; n++) begin
            op  = $urandom_range(0, 1);
            len = $urandom_range(0, 7);
            a   = $urandom_range(0, 255 - len) * 4 + $urandom_range(0, 3);
            if (op == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15));
                end
                do_write(a, len, 3'd2, len);
            end else begin
                do_read(a, len, 3'd2, $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_axi_mem_slave.md
Name: dcache_axi_mem_slave

Overview:
- Memory-side responder for the data cache's simplified AXI master interface; it is the other end of the cache's r_*/ret_*/w_*/b_* signals.
- Accepts single-beat uncached accesses and 16-beat cache-line bursts.
- Serves them from an internal word-addressed RAM, handling read-data, write-data and write-response handshakes.
- Used as the main-memory stand-in for cache-level simulation and FPGA bring-up.

Parameters:
- ADDR_WIDTH, 14, log2 of memory depth in 32-bit words (64 KiB default).
- READ_LATENCY, 2, idle cycles between read acceptance and the first ret_valid (min 1).
- LFSR_SEED, 16'hACE1, seed for the stall generator (optional feature only).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- r_req  in  1  read address valid.
- r_addr  in  32  read start byte address.
- r_size  in  3  0=8b, 1=16b, 2=32b (bursts always 2).
- r_length  in  8  beats minus 1 (0 single, 15 line).
- r_rdy  out  1  read address accepted (one-cycle pulse).
- ret_valid  out  1  read data beat valid.
- ret_last  out  1  final read beat.
- r_data_AXI  out  32  read data.
- r_data_ready  in  1  master accepts read beat.
- w_req  in  1  write address valid.
- w_addr  in  32  write start byte address.
- w_size  in  3  as r_size.
- w_length  in  8  beats minus 1.
- w_rdy  out  1  write address accepted (pulse).
- w_data_req  in  1  write beat valid.
- w_data_AXI  in  32  write data.
- w_strb  in  4  byte enables.
- w_last  in  1  final write beat.
- w_data_ready  out  1  slave accepts write beat.
- b_valid  out  1  write response valid.
- b_ready  in  1  master accepts response.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rstn=0): FSM=IDLE; all outputs 0; beat counters 0; proto_err cleared. RAM contents are not reset.
- FSM states: IDLE, R_LAT, R_BEAT, W_BEAT, W_RESP.
- IDLE:
  - w_req has priority over r_req when both are high. This guarantees a dirty-line writeback lands before the following refill read.
  - On w_req: pulse w_rdy for one cycle; latch w_addr[ADDR_WIDTH+1:2] and w_length; counter=0; go to W_BEAT.
  - Else on r_req: pulse r_rdy; latch word address and r_length; latency counter=READ_LATENCY-1; go to R_LAT.
- R_LAT: decrement each cycle; at 0 go to R_BEAT.
- R_BEAT:
  - ret_valid=1 and r_data_AXI=mem[word]. Data, ret_valid and ret_last stay stable until r_data_ready is high.
  - On a beat handshake: word+1, modulo 2^ADDR_WIDTH (wrap to 0); count+1.
  - ret_last=1 when count==length. A handshake on the last beat returns to IDLE.
  - Narrow reads (size 0/1) return the whole aligned word; the master extracts the bytes.
- W_BEAT:
  - w_data_ready=1. On w_data_req&&w_data_ready, write the bytes of mem[word] selected by w_strb, in the same cycle; word+1 with wrap; count+1.
  - A beat with w_last=1 goes to W_RESP.
  - If w_last=1 while count!=length, or count==length with w_last=0: set proto_err; the beat is still written. On the w_last=0 case, also go to W_RESP.
- W_RESP: b_valid=1 until b_ready; then IDLE.
- r_length/w_length ≠ 0 with size ≠ 2: set proto_err; the burst is still executed as 32-bit beats.
- The address low bits [1:0] are ignored for word selection. Byte placement is the master's job via w_strb and data lane position.
- A request arriving outside IDLE is not acknowledged; the master must hold it.
- An async reset mid-burst aborts the transaction immediately. Partial writes already committed remain in memory.

Optional Feature:
- Macro DMEM_RAND_STALL_EN.
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded LFSR_SEED at reset) advances every cycle.
  - When LFSR[0]=1, ret_valid and w_data_ready are forced to 0 that cycle and no beat transfers. r_rdy/w_rdy are also delayed while LFSR[1]=1.
  - Not defined: no LFSR is instantiated, and the fixed timing above applies exactly.

Test Plan:
- Write-then-read, single beat: write size=2 at 0x0000_0040, data 0xDEADBEEF, strb 4'b1111, length 0 → w_rdy pulse, b_valid. Then read at 0x40, length 0 → r_rdy, then ret_valid at READ_LATENCY cycles after the r_rdy cycle, with r_data_AXI=0xDEADBEEF and ret_last=1.
- Byte strobe: pre-fill 0x11223344 at 0x80; write 0x000000AA with strb 4'b0001 → read returns 0x112233AA.
- Line burst with backpressure: write 16 beats 0..15 to 0x100 with length 15; read back length 15 while r_data_ready toggles 1,0,1,0 → 16 beats in order, data held on stalls, ret_last only on beat 15.
- Simultaneous requests: r_req and w_req high in the same cycle → w_rdy is pulsed first; r_rdy only after the b_valid/b_ready handshake. The read returns the newly written data.
- Wrap and protocol error: burst of length 3 at the last word of memory → beats hit words N-1, 0, 1, 2. A w_last on beat 1 of a length-3 write → proto_err=1 and it stays high until reset.
- Reset mid-burst: drop rstn during beat 5 of a read → ret_valid=0 immediately; after release, FSM is in IDLE and proto_err=0.
